// File: rtl/vga_timing.sv
// vga_timing: free-running VGA raster counters, sync/blank decode and registered DAC output stage.
// Sync and blank are delayed to match the colour mux latency so every pin changes on the same pixel.
module vga_timing #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned PIPE_DLY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dato,
    output logic [9:0]  pixelX,
    output logic [9:0]  pixelY,
    output logic        pixel_tick,
    output logic        frame_start,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic        vga_clk
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    // {hs, vs, vis} while idle: syncs deasserted, outside the visible area
    localparam logic [2:0] SYNC_IDLE = 3'b110;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             pixel_tick_q, pixel_tick_d;
    logic             frame_start_q, frame_start_d;
    logic             vga_clk_q, vga_clk_d;

    logic [23:0]      rgb_q, rgb_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             blank_n_q, blank_n_d;

    logic [2:0]       sync_raw;
    logic [2:0]       sync_tap;
    logic             unused_dato_hi;

    assign unused_dato_hi = ^dato[31:24];

    // Pixel divider and raster counters; counters advance on the last clk of each pixel
    always_comb begin
        div_cnt_d     = div_cnt_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_start_d = 1'b0;

        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        if (pixel_tick_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d       = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_cnt_d = v_cnt_q + CNT_W'(1);
                end
            end else begin
                h_cnt_d = h_cnt_q + CNT_W'(1);
            end
        end

        pixel_tick_d = (div_cnt_d == DIV_LAST);
        vga_clk_d    = (CLK_DIV > 1) ? (div_cnt_d < DIV_HALF) : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pixel_tick_q  <= 1'b0;
            frame_start_q <= 1'b0;
            vga_clk_q     <= 1'b1;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pixel_tick_q  <= pixel_tick_d;
            frame_start_q <= frame_start_d;
            vga_clk_q     <= vga_clk_d;
        end
    end

    // Undelayed decode of the current raster position
    always_comb begin
        sync_raw[2] = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
        sync_raw[1] = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
        sync_raw[0] = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    end

    // Delay line matching the colour mux latency
    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign sync_tap = sync_raw;
        end else begin : g_dly
            logic [2:0] dly_q [PIPE_DLY];
            logic [2:0] dly_d [PIPE_DLY];

            always_comb begin
                dly_d[0] = sync_raw;
                for (int i = 1; i < int'(PIPE_DLY); i++) begin
                    dly_d[i] = dly_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < int'(PIPE_DLY); i++) begin
                        dly_q[i] <= SYNC_IDLE;
                    end
                end else begin
                    for (int i = 0; i < int'(PIPE_DLY); i++) begin
                        dly_q[i] <= dly_d[i];
                    end
                end
            end

            assign sync_tap = dly_q[PIPE_DLY-1];
        end
    endgenerate

    // Output stage: colour is blanked with the delayed visible flag
    always_comb begin
        hs_d      = sync_tap[2];
        vs_d      = sync_tap[1];
        blank_n_d = sync_tap[0];
        rgb_d     = sync_tap[0] ? dato[23:0] : 24'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q     <= 24'h0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            rgb_q     <= rgb_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
        end
    end

    assign pixelX      = h_cnt_q;
    assign pixelY      = v_cnt_q;
    assign pixel_tick  = pixel_tick_q;
    assign frame_start = frame_start_q;
    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_sync_n  = 1'b0;
    assign vga_clk     = vga_clk_q;

endmodule
